// File: rtl/sigmoid_share_arbiter.sv
// Round-robin sharing of one Alippi piecewise sigmoid among N_REQ requesters,
// two-stage pipeline. Define SIGMOID_SHARE_PERF_EN to add stall/done counters.

// Alippi shift-based sigmoid: for x <= 0, y = (1/2 - frac(|x|)/4) >> int(|x|);
// for x > 0 the curve is mirrored, y = 1 - sigmoid(-x).
module sigmoid_alippi #(
   parameter int INT_BIT  = 7,
   parameter int FRAC_BIT = 8
) (
   input  logic [INT_BIT+FRAC_BIT:0] x,
   output logic [FRAC_BIT:0]         y
);
   localparam int W = INT_BIT + FRAC_BIT + 1;
   localparam logic [FRAC_BIT:0] HALF = {2'b01, {(FRAC_BIT-1){1'b0}}};
   localparam logic [FRAC_BIT:0] ONE  = {1'b1, {FRAC_BIT{1'b0}}};

   logic [W-1:0]        mag;
   logic [INT_BIT:0]    int_part;
   logic [FRAC_BIT-1:0] frac_part;
   logic [FRAC_BIT:0]   frac_quarter;
   logic [FRAC_BIT:0]   base;
   logic [FRAC_BIT:0]   neg_half_curve;

   // Most-negative input negates to itself, which read unsigned is the right magnitude.
   assign mag            = x[W-1] ? (~x + 1'b1) : x;
   assign int_part       = mag[W-1:FRAC_BIT];
   assign frac_part      = mag[FRAC_BIT-1:0];
   assign frac_quarter   = {1'b0, frac_part} >> 2;
   assign base           = HALF - frac_quarter;
   assign neg_half_curve = base >> int_part;
   assign y              = x[W-1] ? neg_half_curve : (ONE - neg_half_curve);
endmodule

module sigmoid_share_arbiter #(
   parameter int N_REQ    = 4,
   parameter int INT_BIT  = 7,
   parameter int FRAC_BIT = 8,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [N_REQ-1:0]                     in_valid,
   output logic [N_REQ-1:0]                     in_ready,
   input  logic [N_REQ*(INT_BIT+FRAC_BIT+1)-1:0] in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [FRAC_BIT:0]                    out_data,
   output logic [ID_W-1:0]                      out_id
`ifdef SIGMOID_SHARE_PERF_EN
   ,
   output logic [31:0]                          perf_busy,
   output logic [31:0]                          perf_done
`endif
);
   localparam int W = INT_BIT + FRAC_BIT + 1;
   localparam logic [ID_W:0]   N_REQ_W  = (ID_W+1)'(N_REQ);
   localparam logic [ID_W-1:0] PTR_INIT = ID_W'(N_REQ - 1);

   logic [W-1:0]      req_data [N_REQ];

   logic [ID_W-1:0]   ptr_reg;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_any;
   logic [ID_W:0]     cand;

   logic              s0_valid_reg;
   logic [W-1:0]      s0_data_reg;
   logic [ID_W-1:0]   s0_id_reg;

   logic              out_valid_reg;
   logic [FRAC_BIT:0] out_data_reg;
   logic [ID_W-1:0]   out_id_reg;

   logic              s1_can_load;
   logic              s0_can_load;
   logic              handshake;
   logic [FRAC_BIT:0] sig_result;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
         assign req_data[gi] = in_data[gi*W +: W];
         assign in_ready[gi] = grant_any && (grant_idx == ID_W'(gi)) && s0_can_load;
      end
   endgenerate

   assign s1_can_load = !out_valid_reg || out_ready;
   assign s0_can_load = !s0_valid_reg || s1_can_load;
   assign handshake   = grant_any && s0_can_load;

   // Scan ptr+1, ptr+2, ... with wrap; the first valid requester wins.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, ptr_reg} + k[ID_W:0];
         if (cand >= N_REQ_W) begin
            cand = cand - N_REQ_W;
         end
         if (!grant_any && in_valid[cand[ID_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= PTR_INIT;
      end else if (handshake) begin
         ptr_reg <= grant_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_reg <= 1'b0;
         s0_data_reg  <= '0;
         s0_id_reg    <= '0;
      end else if (handshake) begin
         s0_valid_reg <= 1'b1;
         s0_data_reg  <= req_data[grant_idx];
         s0_id_reg    <= grant_idx;
      end else if (s1_can_load) begin
         s0_valid_reg <= 1'b0;
      end
   end

   sigmoid_alippi #(
      .INT_BIT  (INT_BIT),
      .FRAC_BIT (FRAC_BIT)
   ) u_sigmoid (
      .x (s0_data_reg),
      .y (sig_result)
   );

   // Output stage holds data/id through bubbles; only out_valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_id_reg    <= '0;
      end else if (s1_can_load) begin
         out_valid_reg <= s0_valid_reg;
         if (s0_valid_reg) begin
            out_data_reg <= sig_result;
            out_id_reg   <= s0_id_reg;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_id    = out_id_reg;

`ifdef SIGMOID_SHARE_PERF_EN
   logic [31:0] perf_busy_reg;
   logic [31:0] perf_done_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_reg <= '0;
         perf_done_reg <= '0;
      end else begin
         if (out_valid_reg && !out_ready && (perf_busy_reg != '1)) begin
            perf_busy_reg <= perf_busy_reg + 32'd1;
         end
         if (out_valid_reg && out_ready && (perf_done_reg != '1)) begin
            perf_done_reg <= perf_done_reg + 32'd1;
         end
      end
   end

   assign perf_busy = perf_busy_reg;
   assign perf_done = perf_done_reg;
`endif
endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Self-checking bench for sigmoid_share_arbiter: directed scenarios plus a
// randomized run compared every cycle against a behavioural model.
module tb_sigmoid_share_arbiter;
   localparam int N   = 4;
   localparam int IB  = 7;
   localparam int FB  = 8;
   localparam int W   = IB + FB + 1;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      in_valid;
   logic [N-1:0]      in_ready;
   logic [N*W-1:0]    in_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [FB:0]       out_data;
   logic [IDW-1:0]    out_id;
`ifdef SIGMOID_SHARE_PERF_EN
   logic [31:0]       perf_busy;
   logic [31:0]       perf_done;
`endif

   logic [N-1:0]      req_v = '0;
   logic [W-1:0]      req_d [N];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         in_data[i*W +: W] = req_d[i];
         in_valid[i]       = req_v[i];
      end
   end

   sigmoid_share_arbiter #(.N_REQ(N), .INT_BIT(IB), .FRAC_BIT(FB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
`ifdef SIGMOID_SHARE_PERF_EN
      ,
      .perf_busy (perf_busy),
      .perf_done (perf_done)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference sigmoid straight from the piecewise formula, integer arithmetic.
   function automatic int sig_ref(input int x);
      int mag, n, f, v;
      mag = (x < 0) ? -x : x;
      n   = mag / (1 << FB);
      f   = mag % (1 << FB);
      v   = (1 << (FB - 1)) - f / 4;
      if (n >= 16) v = 0;
      else         v = v / (1 << n);
      return (x < 0) ? v : ((1 << FB) - v);
   endfunction

   // Model: round-robin pointer, one staged item, one presented item.
   int m_ptr, m_s0id, m_s0d, m_od, m_oid;
   bit m_s0v, m_ov;
   longint m_busy, m_done;

   task automatic reset_model();
      m_ptr = N - 1; m_s0v = 0; m_s0id = 0; m_s0d = 0;
      m_ov = 0; m_od = 0; m_oid = 0; m_busy = 0; m_done = 0;
   endtask

   // Called at a falling edge with inputs set; checks, clocks, returns accepted id or -1.
   task automatic step(output int acc);
      bit can1, can0;
      int g, idx;
      logic [N-1:0] exp_ready;
      #1;
      can1 = !m_ov || out_ready;
      can0 = !m_s0v || can1;
      g = -1;
      for (int k = 1; k <= N; k++) begin
         idx = (m_ptr + k) % N;
         if (g < 0 && req_v[idx]) g = idx;
      end
      exp_ready = '0;
      if (g >= 0 && can0) exp_ready[g] = 1'b1;
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_id", out_id, m_oid);
`ifdef SIGMOID_SHARE_PERF_EN
      chk("perf_busy", perf_busy, m_busy);
      chk("perf_done", perf_done, m_done);
`endif
      acc = (g >= 0 && can0) ? g : -1;
      @(posedge clk);
      if (m_ov && !out_ready && m_busy < 64'hFFFF_FFFF) m_busy++;
      if (m_ov && out_ready && m_done < 64'hFFFF_FFFF) m_done++;
      if (can1) begin
         if (m_s0v) begin
            m_od  = sig_ref(m_s0d);
            m_oid = m_s0id;
         end
         m_ov = m_s0v;
      end
      if (acc >= 0) begin
         m_s0v  = 1;
         m_s0id = acc;
         m_s0d  = $signed(req_d[acc]);
         m_ptr  = acc;
      end else if (can1) begin
         m_s0v = 0;
      end
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] rnd_data();
      int t;
      if ($urandom_range(0, 1) == 0) t = $urandom();
      else                          t = int'($urandom_range(0, 2047)) - 1024;
      return t[W-1:0];
   endfunction

   int acc, bp_cnt;
   int q[$];
   logic [FB:0] held;

   initial begin
      for (int i = 0; i < N; i++) req_d[i] = '0;
      reset_model();

      chk("ref_0",   sig_ref(0),       128);
      chk("ref_p1",  sig_ref(256),     192);
      chk("ref_m1",  sig_ref(-256),    64);
      chk("ref_p2",  sig_ref(512),     224);

      @(negedge clk); @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_id", out_id, 0);
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      step(acc);

      // Single request from requester 2, zero operand.
      out_ready = 1'b1;
      req_v[2] = 1'b1; req_d[2] = 16'h0000;
      #1 chk("single_in_ready", in_ready, 4'b0100);
      step(acc);
      req_v[2] = 1'b0;
      step(acc);
      #1;
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 128);
      chk("single_id", out_id, 2);
      step(acc);

      // Back-to-back operands from requester 0.
      req_v[0] = 1'b1; req_d[0] = 16'h0100;
      step(acc); chk("b2b_acc0", acc, 0);
      req_d[0] = 16'hFF00;
      step(acc); chk("b2b_acc1", acc, 0);
      req_d[0] = 16'h0200;
      #1 chk("b2b_res0", out_data, 192);
      step(acc); chk("b2b_acc2", acc, 0);
      req_v[0] = 1'b0;
      #1 chk("b2b_res1", out_data, 64);
      step(acc);
      #1 chk("b2b_res2", out_data, 224);
      chk("b2b_res2_valid", out_valid, 1);
      step(acc);

      // Backpressure: drain, stall, expect exactly two accepts.
      req_v = '0; out_ready = 1'b1;
      repeat (3) step(acc);
      out_ready = 1'b0; req_v = '1;
      for (int i = 0; i < N; i++) req_d[i] = rnd_data();
      bp_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            #1 chk("bp_in_ready", in_ready, 0);
            held = out_data;
         end
         step(acc);
         if (acc >= 0) begin
            bp_cnt++;
            q.push_back(acc);
            req_d[acc] = rnd_data();
         end
      end
      chk("bp_accepts", bp_cnt, 2);
      #1 chk("bp_hold", out_data, held);
      out_ready = 1'b1; req_v = '0;
      repeat (3) begin
         #1 if (out_valid && q.size() > 0) chk("bp_order", out_id, q.pop_front());
         step(acc);
      end
      chk("bp_drained", q.size(), 0);

      // Fill both stages then reset mid-stream.
      out_ready = 1'b0; req_v = '1;
      repeat (3) begin
         step(acc);
         if (acc >= 0) req_d[acc] = rnd_data();
      end
      #1 chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1 chk("async_rst_valid", out_valid, 0);
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;

      // Fairness after reset: requester 0 first, then strict rotation.
      out_ready = 1'b1; req_v = '1;
      for (int k = 0; k < 8; k++) begin
         step(acc);
         chk("fair_grant", acc, k % N);
         if (acc >= 0) req_d[acc] = rnd_data();
      end

`ifdef SIGMOID_SHARE_PERF_EN
      rst_n = 1'b0;
      #1 reset_model();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b0; req_v = '1;
      repeat (2) step(acc);
      repeat (5) step(acc);
      out_ready = 1'b1;
      repeat (3) begin
         step(acc);
         if (acc >= 0) req_d[acc] = rnd_data();
      end
      out_ready = 1'b0; req_v = '0;
      #1;
      chk("perf_busy_lit", perf_busy, 5);
      chk("perf_done_lit", perf_done, 3);
      step(acc);
`endif

      // Randomized traffic with random backpressure and request drops.
      req_v = '0;
      for (int c = 0; c < 3000; c++) begin
         out_ready = ($urandom_range(0, 99) < 70);
         step(acc);
         if (acc >= 0) req_v[acc] = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!req_v[i]) begin
               if ($urandom_range(0, 99) < 40) begin
                  req_v[i] = 1'b1;
                  req_d[i] = rnd_data();
               end
            end else if ($urandom_range(0, 99) < 5) begin
               req_v[i] = 1'b0;
            end
         end
      end
      out_ready = 1'b1; req_v = '0;
      repeat (4) step(acc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
